// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO pair.
// Optional signed operation is enabled by defining MULDIV_SIGNED_EN.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
`ifdef MULDIV_SIGNED_EN
  input  logic             op_signed,
`endif
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div0
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op_div, r_neg_res, r_neg_rem, r_div0;
  logic [WIDTH-1:0]   r_opnd, r_acc_hi, r_acc_lo, r_hi, r_lo;

  logic               w_last;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_addend;
  logic               w_neg_res, w_neg_rem;
  logic [WIDTH:0]     w_add, w_trial;
  logic [WIDTH-1:0]   w_hi_nx, w_lo_nx, w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_prod;

`ifdef MULDIV_SIGNED_EN
  logic w_sa, w_sb;
  assign w_sa      = op_signed & src_a[WIDTH-1];
  assign w_sb      = op_signed & src_b[WIDTH-1];
  assign w_mag_a   = w_sa ? -src_a : src_a;
  assign w_mag_b   = w_sb ? -src_b : src_b;
  assign w_neg_res = w_sa ^ w_sb;
  assign w_neg_rem = w_sa;
`else
  assign w_mag_a   = src_a;
  assign w_mag_b   = src_b;
  assign w_neg_res = 1'b0;
  assign w_neg_rem = 1'b0;
`endif

  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
  assign rd_data = rd_sel ? r_hi : r_lo;
  assign div0    = r_div0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    stall      = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nx = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nx = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    stall = busy & (rd_req | start);
  end

  // Accumulator is shared: multiply uses {P_hi,P_lo}, divide uses {R,Q}.
  // r_opnd holds the multiplicand for multiply and the divisor for divide.
  assign w_addend = r_acc_lo[0] ? r_opnd : '0;

  always_comb begin
    w_add   = {1'b0, r_acc_hi} + {1'b0, w_addend};
    w_trial = {r_acc_hi, r_acc_lo[WIDTH-1]} - {1'b0, r_opnd};
    if (r_op_div) begin
      // R < divisor holds throughout, so a restored R always fits WIDTH bits.
      if (w_trial[WIDTH]) begin
        w_hi_nx = {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
        w_lo_nx = {r_acc_lo[WIDTH-2:0], 1'b0};
      end else begin
        w_hi_nx = w_trial[WIDTH-1:0];
        w_lo_nx = {r_acc_lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      w_hi_nx = w_add[WIDTH:1];
      w_lo_nx = {w_add[0], r_acc_lo[WIDTH-1:1]};
    end

    w_prod = r_neg_res ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    if (r_op_div) begin
      w_res_lo = r_neg_res ? -r_acc_lo : r_acc_lo;
      w_res_hi = r_neg_rem ? -r_acc_hi : r_acc_hi;
    end else begin
      w_res_lo = w_prod[WIDTH-1:0];
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_op_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_opnd    <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt     <= '0;
            r_op_div  <= op_div;
            r_neg_res <= w_neg_res;
            r_neg_rem <= w_neg_rem;
            r_div0    <= 1'b0;
            r_opnd    <= op_div ? w_mag_b : w_mag_a;
            r_acc_hi  <= '0;
            r_acc_lo  <= op_div ? w_mag_a : w_mag_b;
          end
        end
        S_RUN: begin
          r_cnt    <= r_cnt + 1'b1;
          r_acc_hi <= w_hi_nx;
          r_acc_lo <= w_lo_nx;
        end
        S_DONE: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
          if (r_op_div && (r_opnd == '0)) r_div0 <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, hand sequences, random ops vs. arithmetic model.
module tb_muldiv_sequencer;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, op_div, rd_req, rd_sel;
  logic [W-1:0] src_a, src_b, rd_data;
  logic         busy, stall, done, div0;
`ifdef MULDIV_SIGNED_EN
  logic         op_signed;
`endif

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] m_hi, m_lo;

  typedef struct {
    string        name;
    bit           dv;
    logic [W-1:0] a, b, hi, lo;
    bit           d0;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div),
`ifdef MULDIV_SIGNED_EN
    .op_signed(op_signed),
`endif
    .src_a(src_a), .src_b(src_b), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .stall(stall), .done(done), .div0(div0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
    rd_sel = 1'b0; #1 lo = rd_data;
    rd_sel = 1'b1; #1 hi = rd_data;
    rd_sel = 1'b0;
  endtask

  task automatic run_op(input string name, input bit dv, input bit sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input bit exp_d0);
    int cnt;
    logic [W-1:0] hi, lo;
    start = 1'b1; op_div = dv; src_a = a; src_b = b;
`ifdef MULDIV_SIGNED_EN
    op_signed = sgn;
`else
    if (sgn) $display("note: signed request ignored in unsigned build");
`endif
    tick;
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    check({name, "_busy_after_start"}, busy, 1);
    check({name, "_div0_cleared"}, div0, 0);
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin
      tick;
      cnt++;
    end
    check({name, "_done_latency"}, cnt, W);
    check({name, "_rd_old_in_done"}, rd_data, m_lo);
    tick;
    check({name, "_busy_after_done"}, busy, 0);
    check({name, "_done_single"}, done, 0);
    read_hilo(hi, lo);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
    check({name, "_div0"}, div0, exp_d0);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] hi, lo, a, b;
    logic [63:0]  p;
    int           cnt, bad;
    bit           dv, seen;

    vecs[0] = '{"mul_7x6",      1'b0, 32'd7,        32'd6,        32'h0,        32'h2A,       1'b0};
    vecs[1] = '{"mul_max",      1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{"div_100_7",    1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[3] = '{"div_5_0",      1'b1, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    vecs[4] = '{"mul_shift",    1'b0, 32'h12345678, 32'h10,       32'h1,        32'h23456780, 1'b0};
    vecs[5] = '{"div_max_1",    1'b1, 32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[6] = '{"mul_msb_x2",   1'b0, 32'h80000000, 32'd2,        32'h1,        32'h0,        1'b0};
    vecs[7] = '{"div_3_10",     1'b1, 32'd3,        32'd10,       32'd3,        32'd0,        1'b0};
    vecs[8] = '{"mul_0",        1'b0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        1'b0};
    vecs[9] = '{"div_1234_0",   1'b1, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 1'b1};

    rst = 1'b1; start = 1'b0; op_div = 1'b0; rd_req = 1'b0; rd_sel = 1'b0;
    src_a = '0; src_b = '0;
`ifdef MULDIV_SIGNED_EN
    op_signed = 1'b0;
`endif
    m_hi = '0; m_lo = '0;
    tick; tick;
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_div0", div0, 0);
    read_hilo(hi, lo);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].dv, 1'b0, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].d0);

    // Read in the launch cycle sees old data; read during busy holds the pipe.
    start = 1'b1; op_div = 1'b0; src_a = 32'h10000; src_b = 32'h30000;
    rd_req = 1'b1; rd_sel = 1'b1;
    #1;
    check("idle_start_rd_stall", stall, 0);
    check("idle_start_rd_data", rd_data, m_hi);
    tick;
    start = 1'b0; rd_req = 1'b0;
    #1;
    check("run_no_req_stall", stall, 0);
    start = 1'b1; op_div = 1'b1; src_a = 32'd1; src_b = 32'd0;
    #1;
    check("busy_start_stall", stall, 1);
    tick;
    start = 1'b0; rd_req = 1'b1; rd_sel = 1'b1;
    bad = 0; cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin
      if (stall !== 1'b1) bad++;
      tick;
      cnt++;
    end
    check("rd_stall_cycles_low", bad, 0);
    check("rd_wait_len", cnt, W - 1);
    check("rd_stall_in_done", stall, 1);
    check("rd_old_hi_in_done", rd_data, m_hi);
    tick;
    check("rd_stall_released", stall, 0);
    check("rd_new_hi", rd_data, 32'h3);
    rd_req = 1'b0;
    tick;
    check("ignored_start_idle", busy, 0);
    check("ignored_start_div0", div0, 0);
    read_hilo(hi, lo);
    check("rd_new_lo", lo, 32'h0);
    m_hi = 32'h3; m_lo = 32'h0;

    for (int k = 0; k < 24; k++) begin
      dv = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = dv ? 32'd0 : 32'd1;
        1, 2:    b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      if (dv) begin
        if (b == 0) run_op("rnd_div", 1'b1, 1'b0, a, b, a, '1, 1'b1);
        else        run_op("rnd_div", 1'b1, 1'b0, a, b, a % b, a / b, 1'b0);
      end else begin
        p = 64'(a) * 64'(b);
        run_op("rnd_mul", 1'b0, 1'b0, a, b, p[63:32], p[31:0], 1'b0);
      end
    end

    // Reset partway through RUN abandons the operation silently.
    start = 1'b1; op_div = 1'b0; src_a = 32'd7; src_b = 32'd6;
    tick;
    start = 1'b0;
    repeat (10) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    read_hilo(hi, lo);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    seen = 1'b0;
    repeat (40) begin
      tick;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("midrst_quiet", seen, 0);
    m_hi = '0; m_lo = '0;
    run_op("post_rst_mul", 1'b0, 1'b0, 32'd9, 32'd11, 32'd0, 32'd99, 1'b0);

`ifdef MULDIV_SIGNED_EN
    run_op("sdiv_m7_2", 1'b1, 1'b1, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("smul_m3_4", 1'b0, 1'b1, -32'sd3, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0);
    for (int k = 0; k < 8; k++) begin
      longint sa, sb, r;
      logic [63:0] rv, qv;
      dv = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      if (k % 2 == 0) b = 32'(-$urandom_range(1, 100));
      if (b == 0) b = 32'd3;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (dv) begin
        qv = 64'(sa / sb);
        rv = 64'(sa % sb);
        run_op("rnd_sdiv", 1'b1, 1'b1, a, b, rv[31:0], qv[31:0], 1'b0);
      end else begin
        r  = sa * sb;
        rv = 64'(r);
        run_op("rnd_smul", 1'b0, 1'b1, a, b, rv[63:32], rv[31:0], 1'b0);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle iterative multiply/divide unit with its own control FSM. It owns the HI/LO register pair.
- Decode raises `start` for mult/div opcodes. mfhi/mflo reads go through `rd_req`.
- While an operation runs, the block stalls the rest of the datapath.
- Uses shift-add multiply and restoring divide: one bit per cycle, so no wide multiplier or divider is synthesised.

Parameters:
WIDTH, 32, operand width; HI, LO and `rd_data` are all WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, all state updates on the rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  request a new operation; sampled only in IDLE.
op_div  input  1  0 = multiply, 1 = divide; sampled with `start`.
src_a  input  WIDTH  multiplicand / dividend; sampled with `start`.
src_b  input  WIDTH  multiplier / divisor; sampled with `start`.
rd_req  input  1  mfhi/mflo read request.
rd_sel  input  1  0 = LO, 1 = HI.
rd_data  output  WIDTH  selected HI/LO value (combinational mux of the registers).
busy  output  1  high whenever state != IDLE.
stall  output  1  pipeline hold request.
done  output  1  high for exactly the one cycle spent in DONE.
div0  output  1  sticky divide-by-zero flag.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state = IDLE, HI = 0, LO = 0, counter = 0, `busy` = 0, `stall` = 0, `done` = 0, `div0` = 0.
- Reset mid-operation: the operation is abandoned and HI/LO are cleared; no `done` pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start` = 1 at edge E0: latch the operands, operation type and counter = 0, then go to RUN.
  - `start` = 0: remain in IDLE.
- RUN: one iteration per edge. After exactly WIDTH RUN edges (E1..E_WIDTH) go to DONE.
- DONE: `done` = 1 for this cycle. At edge E_WIDTH+1, HI and LO are written and the state returns to IDLE.
- Total latency: WIDTH+2 edges from `start` to HI/LO visible, i.e. 34 for WIDTH = 32.
- Multiply datapath:
  - 2·WIDTH-bit accumulator {P_hi, P_lo}, with P_lo initialised to `src_b` and P_hi to 0.
  - Each iteration: if P_lo[0] is 1, P_hi += `src_a` with carry; then the whole accumulator shifts right by 1, carry entering the MSB.
  - Result: HI = upper WIDTH bits of the product, LO = lower WIDTH bits.
- Divide datapath:
  - Restoring algorithm; remainder R is WIDTH+1 bits, quotient Q is shifted in LSB-first.
  - Each iteration: R = {R, Q_msb} − divisor. If the result is negative, restore R and shift in 0; otherwise keep R and shift in 1.
  - Result: LO = quotient, HI = remainder.
- Divide by zero:
  - No special datapath path; the algorithm naturally yields LO = all-ones and HI = dividend.
  - `div0` is set at the DONE edge of that operation and stays set until the next accepted `start` clears it.
- Stall: `stall` = `busy` & (`rd_req` | `start`).
  - A `start` while busy is ignored and held off by `stall`; the requester must hold it.
  - A read while busy stalls until the cycle after DONE.
- Same-cycle `start` and `rd_req` in IDLE: the read returns the old HI/LO with no stall, and the operation launches normally.
- `rd_data` during DONE still shows the old values; the new values appear from the next cycle.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - Extra input `op_signed` (1 bit), sampled with `start`.
  - When `op_signed` = 1, operands are converted to magnitudes at E0 and their sign bits are recorded.
  - At the DONE edge:
    - the product is negated (2·WIDTH-bit two's complement) if the operand signs differ;
    - the quotient is negated if the signs differ;
    - the remainder takes the sign of the dividend.
  - Latency is unchanged.
- Not defined: the port is absent and all operations are unsigned.

Test Plan:
- Multiply 7 × 6: LO = 0x0000002A, HI = 0, `done` pulses at cycle 33 after `start`, `busy` low at cycle 34.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF: HI = 0xFFFFFFFE, LO = 0x00000001.
- Divide 100 / 7: LO = 14, HI = 2. Then 5 / 0: LO = 0xFFFFFFFF, HI = 5, `div0` = 1; `div0` clears on the next `start`.
- `rd_req` with `rd_sel` = 1 asserted two cycles after a multiply `start`: `stall` = 1 continuously until the cycle after DONE, then `rd_data` = new HI with `stall` = 0. A second `start` issued while busy is ignored.
- `rst` pulsed at RUN iteration 10: the next cycle shows `busy` = 0, HI = LO = 0 and no `done` pulse. A fresh `start` then completes normally.
- (MULDIV_SIGNED_EN) Signed −7 / 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Signed −3 × 4: HI = 0xFFFFFFFF, LO = 0xFFFFFFF4.
